morse_pattern_tx: RTL

//  Parametrised serial pattern transmitter for the Morse/LED labs. It latches a pattern

---
 rtl/morse_pattern_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/morse_pattern_tx.sv
// morse_pattern_tx
//   Serial pattern transmitter. Latches a pattern word and a symbol count on
//   start, then shifts the pattern out LSB-first on q, holding each symbol for
//   DIV clocks. Optional auto-repeat with a GAP_UNITS-symbol gap of q=0.
// Ports:
//   clk        system clock
//   clear      synchronous reset, active-high (overrides everything)
//   start      request a transmission (only honoured in IDLE)
//   stop       synchronous abort, any state
//   repeat_en  restart after the gap at the end of each pass
//   pattern    symbol bits, bit 0 sent first
//   length     symbols to send; 0 ignores start, >PAT_W clamps to PAT_W
//   q          registered serial output
//   busy       high in SEND or GAP
//   done       one-cycle pulse at the end of each completed pass
module morse_pattern_tx #(
  parameter int PAT_W     = 14,
  parameter int LEN_W     = 4,
  parameter int DIV       = 25000000,
  parameter int GAP_UNITS = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             repeat_en,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  output logic             q,
  output logic             busy,
  output logic             done
);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = ($clog2(PAT_W + 1) > 0) ? $clog2(PAT_W + 1) : 1;
  localparam int GAP_W = (GAP_UNITS * DIV > 0) ? $clog2(GAP_UNITS * DIV + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_UNITS * DIV - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [PAT_W-1:0] pat;      // latched pattern, reloaded into sh on repeat
  logic [PAT_W-1:0] sh;       // shift register, sh[0] is the symbol on q
  logic [BIT_W-1:0] len;      // latched, clamped length
  logic [BIT_W-1:0] bit_cnt;  // index of the symbol currently on q
  logic [DIV_W-1:0] div_cnt;  // cycles left in the current symbol
  logic [GAP_W-1:0] gap_cnt;  // cycles left in the inter-word gap

  logic [LEN_W-1:0] len_clamp;
  logic [PAT_W-1:0] sh_next;

  assign len_clamp = (length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : length;
  assign sh_next   = sh >> 1;

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      pat     <= '0;
      sh      <= '0;
      len     <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      q       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (stop) begin
      // Abort keeps the latched pattern/length but drops everything in flight.
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      q       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          q    <= 1'b0;
          busy <= 1'b0;
          if (start && length != '0) begin
            pat     <= pattern;
            sh      <= pattern;
            len     <= BIT_W'(len_clamp);
            bit_cnt <= '0;
            div_cnt <= DIV_LOAD;
            q       <= pattern[0];
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else if (bit_cnt == len - BIT_W'(1)) begin
            // Last symbol finished: end of pass.
            done    <= 1'b1;
            bit_cnt <= '0;
            if (repeat_en) begin
              if (GAP_UNITS > 0) begin
                state   <= GAP;
                q       <= 1'b0;
                gap_cnt <= GAP_LOAD;
              end else begin
                sh      <= pat;
                q       <= pat[0];
                div_cnt <= DIV_LOAD;
              end
            end else begin
              state <= IDLE;
              q     <= 1'b0;
              busy  <= 1'b0;
            end
          end else begin
            sh      <= sh_next;
            q       <= sh_next[0];
            bit_cnt <= bit_cnt + BIT_W'(1);
            div_cnt <= DIV_LOAD;
          end
        end
        GAP: begin
          q <= 1'b0;
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else begin
            state   <= SEND;
            sh      <= pat;
            q       <= pat[0];
            bit_cnt <= '0;
            div_cnt <= DIV_LOAD;
          end
        end
        default: begin
          state <= IDLE;
          q     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
